// File: rtl/toggle_monitor.sv
// toggle_monitor
//   Watches the q output of an upstream T flip-flop stage over a programmable
//   window of clk cycles. It counts toggles, tracks the longest run of
//   consecutive samples without a toggle, and hands one result record per
//   window to a consumer over a valid/ready handshake.
//
// Ports
//   clk          clock, all registers update on the rising edge
//   rst_n        asynchronous active-low reset
//   q_i          T flip-flop output, synchronous to clk
//   start_i      request to open a window (only honoured while idle)
//   win_len_i    window length in cycles, captured when start_i is accepted
//   res_ready_i  consumer can take the result this cycle
//   res_valid_o  result record is valid
//   toggles_o    number of q toggles seen in the window (saturating)
//   max_run_o    longest run of window samples without a toggle (saturating)
//   final_q_o    q value at the last window sample
//   ovf_o        toggle count saturated during the window
//   busy_o       high while a window is being counted or reported
module toggle_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_i,
  input  logic             start_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic             res_ready_i,
  output logic             res_valid_o,
  output logic [CNT_W-1:0] toggles_o,
  output logic [CNT_W-1:0] max_run_o,
  output logic             final_q_o,
  output logic             ovf_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    REPORT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             prevQ_q, prevQ_d;
  logic [WIN_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] toggles_q, toggles_d;
  logic [CNT_W-1:0] maxRun_q, maxRun_d;
  logic             finalQ_q, finalQ_d;
  logic             ovf_q, ovf_d;
  logic             resValid_q, resValid_d;
  logic             busy_q, busy_d;

  logic             tog;
  logic [CNT_W-1:0] runNext;

  // State and datapath register bank. Everything clears on reset, which
  // also throws away any window in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prevQ_q     <= 1'b0;
      remaining_q <= '0;
      run_q       <= '0;
      toggles_q   <= '0;
      maxRun_q    <= '0;
      finalQ_q    <= 1'b0;
      ovf_q       <= 1'b0;
      resValid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prevQ_q     <= prevQ_d;
      remaining_q <= remaining_d;
      run_q       <= run_d;
      toggles_q   <= toggles_d;
      maxRun_q    <= maxRun_d;
      finalQ_q    <= finalQ_d;
      ovf_q       <= ovf_d;
      resValid_q  <= resValid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath logic. prevQ_q holds the previous sample of q,
  // so a toggle is simply a difference between this sample and the last one.
  always_comb begin
    state_d     = state_q;
    prevQ_d     = prevQ_q;
    remaining_d = remaining_q;
    run_d       = run_q;
    toggles_d   = toggles_q;
    maxRun_d    = maxRun_q;
    finalQ_d    = finalQ_q;
    ovf_d       = ovf_q;
    resValid_d  = resValid_q;

    tog     = q_i ^ prevQ_q;
    runNext = (run_q == CNT_MAX) ? run_q : run_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        // A zero-length window would never produce a sample, so it is ignored.
        if (start_i && (win_len_i != '0)) begin
          state_d     = COUNT;
          remaining_d = win_len_i;
          toggles_d   = '0;
          run_d       = '0;
          maxRun_d    = '0;
          ovf_d       = 1'b0;
          prevQ_d     = q_i;
        end
      end

      COUNT: begin
        prevQ_d     = q_i;
        finalQ_d    = q_i;
        remaining_d = remaining_q - WIN_W'(1);
        if (tog) begin
          run_d = '0;
          if (toggles_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            toggles_d = toggles_q + CNT_W'(1);
          end
        end else begin
          run_d = runNext;
          if (runNext > maxRun_q) begin
            maxRun_d = runNext;
          end
        end
        if (remaining_q == WIN_W'(1)) begin
          state_d = REPORT;
        end
      end

      REPORT: begin
        // res_valid comes up on the first REPORT cycle, one cycle after the
        // last sample; the transfer needs it already high when ready is seen.
        if (resValid_q && res_ready_i) begin
          state_d    = IDLE;
          resValid_d = 1'b0;
        end else begin
          resValid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign res_valid_o = resValid_q;
  assign toggles_o   = toggles_q;
  assign max_run_o   = maxRun_q;
  assign final_q_o   = finalQ_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_toggle_monitor.sv
// tb_toggle_monitor
//   Self-checking bench for toggle_monitor. A small T flip-flop in the bench
//   produces q from a t pattern. A window-level model records every sample of
//   a window and derives the result record from the sample list, and a
//   compare process checks the DUT against it on every falling edge.
module tb_toggle_monitor;

  localparam int CNT_W = 4;
  localparam int WIN_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             q;
  logic             tIn;
  logic             start;
  logic [WIN_W-1:0] winLen;
  logic             resReady;
  logic             resValid;
  logic [CNT_W-1:0] toggles;
  logic [CNT_W-1:0] maxRun;
  logic             finalQ;
  logic             ovf;
  logic             busy;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state
  bit mActive;
  bit mDone;
  int mLen;
  bit samples[$];
  bit expValid;
  bit expBusy;
  bit expFinalQ;
  bit expOvf;
  int expToggles;
  int expMaxRun;

  always #5 clk = ~clk;

  toggle_monitor #(
    .CNT_W(CNT_W),
    .WIN_W(WIN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q_i        (q),
    .start_i    (start),
    .win_len_i  (winLen),
    .res_ready_i(resReady),
    .res_valid_o(resValid),
    .toggles_o  (toggles),
    .max_run_o  (maxRun),
    .final_q_o  (finalQ),
    .ovf_o      (ovf),
    .busy_o     (busy)
  );

  // Upstream T flip-flop feeding the monitor
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= q ^ tIn;
  end

  // Result of a whole window from its sample list: toggles are neighbouring
  // samples that differ, runs are stretches of equal neighbours.
  function automatic void computeResult();
    int cnt  = 0;
    int run  = 0;
    int best = 0;
    for (int i = 1; i < samples.size(); i++) begin
      if (samples[i] != samples[i-1]) begin
        cnt++;
        run = 0;
      end else begin
        run++;
        if (run > best) best = run;
      end
    end
    expOvf     = (cnt > CMAX);
    expToggles = (cnt > CMAX) ? CMAX : cnt;
    expMaxRun  = (best > CMAX) ? CMAX : best;
    expFinalQ  = samples[samples.size()-1];
  endfunction

  // Window-level model: collect the baseline plus win_len samples, publish the
  // result one cycle after the last sample, retire it on valid && ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mActive    = 1'b0;
      mDone      = 1'b0;
      samples.delete();
      expValid   = 1'b0;
      expBusy    = 1'b0;
      expFinalQ  = 1'b0;
      expOvf     = 1'b0;
      expToggles = 0;
      expMaxRun  = 0;
    end else begin
      if (!mActive) begin
        if (start && (winLen != 0)) begin
          mActive    = 1'b1;
          mDone      = 1'b0;
          mLen       = int'(winLen);
          samples.delete();
          samples.push_back(q);
          expToggles = 0;
          expMaxRun  = 0;
          expOvf     = 1'b0;
        end
      end else if (!mDone) begin
        samples.push_back(q);
        if (samples.size() == mLen + 1) begin
          computeResult();
          mDone = 1'b1;
        end
      end else if (!expValid) begin
        expValid = 1'b1;
      end else if (resReady) begin
        expValid = 1'b0;
        mActive  = 1'b0;
      end
      expBusy = mActive;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Compare process: handshake and busy every cycle, result fields whenever
  // they are meant to be stable (idle or while the result is offered).
  always @(negedge clk) begin
    checkOutput("res_valid", 32'(resValid), 32'(expValid));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    if (expValid || !expBusy) begin
      checkOutput("toggles", 32'(toggles), 32'(expToggles));
      checkOutput("max_run", 32'(maxRun), 32'(expMaxRun));
      checkOutput("final_q", 32'(finalQ), 32'(expFinalQ));
      checkOutput("ovf", 32'(ovf), 32'(expOvf));
    end
  end

  // Open a window and wait for its result; latency counts clock edges from
  // the start edge to the edge that raises res_valid.
  task automatic applyStimulus(input int len, input logic [15:0] pattern,
                               output int latency);
    @(negedge clk);
    start  = 1'b1;
    winLen = WIN_W'(len);
    tIn    = pattern[0];
    @(negedge clk);
    start   = 1'b0;
    latency = 0;
    while (!resValid && latency < 300) begin
      tIn = pattern[(latency + 1) % 16];
      @(negedge clk);
      latency++;
    end
    if (!resValid) checkOutput("res_valid_timeout", 32'(resValid), 32'd1);
  endtask

  task automatic forceQLow();
    tIn = 1'b0;
    if (q) begin
      tIn = 1'b1;
      @(negedge clk);
      tIn = 1'b0;
    end
  endtask

  initial begin
    int lat;
    rst_n    = 1'b0;
    start    = 1'b0;
    winLen   = '0;
    resReady = 1'b1;
    tIn      = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_res_valid", 32'(resValid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_toggles", 32'(toggles), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // win_len == 0 is ignored
    start  = 1'b1;
    winLen = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("zero_len_busy", 32'(busy), 32'd0);

    // q toggles every cycle, 8-cycle window
    applyStimulus(8, 16'hFFFF, lat);
    checkOutput("t2_latency", 32'(lat), 32'd9);
    checkOutput("t2_toggles", 32'(toggles), 32'd8);
    checkOutput("t2_max_run", 32'(maxRun), 32'd0);
    checkOutput("t2_ovf", 32'(ovf), 32'd0);
    @(negedge clk);

    // q held low, 5-cycle window
    forceQLow();
    applyStimulus(5, 16'h0000, lat);
    checkOutput("t3_latency", 32'(lat), 32'd6);
    checkOutput("t3_toggles", 32'(toggles), 32'd0);
    checkOutput("t3_max_run", 32'(maxRun), 32'd5);
    checkOutput("t3_final_q", 32'(finalQ), 32'd0);
    @(negedge clk);

    // toggle count saturation with a 4-bit counter
    applyStimulus(20, 16'hFFFF, lat);
    checkOutput("t4_toggles", 32'(toggles), 32'd15);
    checkOutput("t4_ovf", 32'(ovf), 32'd1);
    @(negedge clk);

    // run-length saturation
    applyStimulus(20, 16'h0000, lat);
    checkOutput("t4b_max_run", 32'(maxRun), 32'd15);
    checkOutput("t4b_ovf", 32'(ovf), 32'd0);
    @(negedge clk);

    // mixed pattern, checked by the model only
    applyStimulus(12, 16'b0011_1000_0110_0101, lat);
    @(negedge clk);

    // back-pressure: hold ready low, pulse start, then release
    resReady = 1'b0;
    applyStimulus(6, 16'b1010_0110_1100_1001, lat);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        start  = 1'b1;
        winLen = WIN_W'(5);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("t5_held_valid", 32'(resValid), 32'd1);
    resReady = 1'b1;
    @(negedge clk);
    checkOutput("t5_after_valid", 32'(resValid), 32'd0);
    checkOutput("t5_after_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // reset three cycles into a 10-cycle window
    start  = 1'b1;
    winLen = WIN_W'(10);
    tIn    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_busy", 32'(busy), 32'd0);
    checkOutput("t6_async_valid", 32'(resValid), 32'd0);
    checkOutput("t6_async_toggles", 32'(toggles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(4, 16'b0110_1101_0010_1011, lat);
    checkOutput("t6_latency", 32'(lat), 32'd5);
    checkOutput("t6_toggles_le4", 32'(toggles <= 4), 32'd1);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
